// File: rtl/rom_streamer.sv
// -----------------------------------------------------------------------------
// rom_streamer
//   Reads 16-bit words from a synchronous ROM (one-clock registered read
//   latency) and streams them out as bytes over a valid/ready interface,
//   low byte first. Each word takes READ -> LATCH -> LO -> HI, so with the
//   sink always ready a word costs four clocks.
//
// Optional feature (macro ROM_STREAMER_CHKSUM_EN):
//   When defined, an 8-bit modulo-256 sum of every transferred byte is
//   appended as one extra byte (state CHK) before DONE. A zero-length
//   request then produces a single 0x00 checksum byte.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   start_i      : transfer request, only looked at in IDLE
//   start_addr_i : first ROM word address
//   length_i     : number of 16-bit words to stream
//   abort_i      : cancel the transfer in progress
//   busy_o       : high whenever the FSM is not in IDLE
//   done_o       : one-cycle pulse on normal completion
//   data_o       : stream byte
//   valid_o      : data_o valid
//   ready_i      : sink accepts data_o this cycle
//   rom_addr_o   : ROM read address
//   rom_clke_o   : ROM clock enable (read strobe)
//   rom_data_i   : ROM registered read data
// -----------------------------------------------------------------------------
module rom_streamer #(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_clke_o,
  input  logic [15:0]           rom_data_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_LO    = 3'd3,
    S_HI    = 3'd4,
`ifdef ROM_STREAMER_CHKSUM_EN
    S_CHK   = 3'd6,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [15:0]           r_word;
  logic                  w_valid;
  logic [7:0]            w_data;
  logic                  w_start;
`ifdef ROM_STREAMER_CHKSUM_EN
  logic [7:0]            r_chksum;
`endif

  // State after the last word (or after a zero-length request).
  state_t                w_tail_state;
`ifdef ROM_STREAMER_CHKSUM_EN
  assign w_tail_state = S_CHK;
`else
  assign w_tail_state = S_DONE;
`endif

  assign w_start = (r_state == S_IDLE) && start_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_data       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = (length_i != '0) ? S_READ : w_tail_state;
        end
      end
      S_READ:  w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_LO;
      S_LO: begin
        w_valid = 1'b1;
        w_data  = r_word[7:0];
        if (ready_i) w_next_state = S_HI;
      end
      S_HI: begin
        w_valid = 1'b1;
        w_data  = r_word[15:8];
        if (ready_i) w_next_state = (r_rem != '0) ? S_READ : w_tail_state;
      end
`ifdef ROM_STREAMER_CHKSUM_EN
      S_CHK: begin
        w_valid = 1'b1;
        w_data  = r_chksum;
        if (ready_i) w_next_state = S_DONE;
      end
`endif
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // Abort wins over everything outside IDLE; in IDLE a coincident start
    // still launches the transfer.
    if (abort_i && (r_state != S_IDLE)) w_next_state = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start && (length_i != '0)) begin
        r_addr <= start_addr_i;
        r_rem  <= length_i;
      end
      // ROM data addressed in READ is valid one clock later, in LATCH.
      if (r_state == S_LATCH) begin
        r_word <= rom_data_i;
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - LEN_WIDTH'(1);
      end
    end
  end

`ifdef ROM_STREAMER_CHKSUM_EN
  // Only data bytes are summed; the checksum byte itself is not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chksum <= 8'h00;
    end else if (w_start) begin
      r_chksum <= 8'h00;
    end else if (ready_i && ((r_state == S_LO) || (r_state == S_HI))) begin
      r_chksum <= r_chksum + w_data;
    end
  end
`endif

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign valid_o    = w_valid;
  assign data_o     = w_data;
  assign rom_clke_o = (r_state == S_READ);
  assign rom_addr_o = r_addr;

endmodule

// File: tb/tb_rom_streamer.sv
// -----------------------------------------------------------------------------
// tb_rom_streamer
//   Directed self-checking bench for rom_streamer with a registered-read ROM
//   model. Works with and without ROM_STREAMER_CHKSUM_EN defined.
// -----------------------------------------------------------------------------
module tb_rom_streamer;

  localparam int AW = 9;
  localparam int LW = 10;
`ifdef ROM_STREAMER_CHKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic [AW-1:0] rom_addr;
  logic          rom_clke;
  logic [15:0]   rom_q;

  logic [15:0]   mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Registered ROM: one clock from strobe to data.
  always @(posedge clk) if (rom_clke) rom_q <= mem[rom_addr];

  rom_streamer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .length_i     (length),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .rom_addr_o   (rom_addr),
    .rom_clke_o   (rom_clke),
    .rom_data_i   (rom_q)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors sample 1 ns before each rising edge; inputs change on falling edges.
  logic [15:0] byte_q[$];
  logic [15:0] addr_q[$];
  int          done_cnt = 0;

  always begin
    @(negedge clk);
    #4;
    if (valid && ready) byte_q.push_back(16'(data));
    if (rom_clke) addr_q.push_back(16'(rom_addr));
    if (done) done_cnt++;
  end

  task automatic check_q(input string tag, input logic [15:0] got[$], input logic [15:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  task automatic clear_mon();
    byte_q.delete();
    addr_q.delete();
  endtask

  // Called on a falling edge in IDLE. Returns the falling-edge index (start
  // edge = 0) on which done_o is seen, or -1 if it never comes.
  task automatic run(input logic [AW-1:0] a, input logic [LW-1:0] l, output int done_at);
    done_at    = -1;
    start      = 1'b1;
    start_addr = a;
    length     = l;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          done_at;
    int          snap;
    logic [15:0] exp_b[$];
    logic [15:0] exp_a[$];

    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 257 + 7);
    mem[0]   = 16'h2405;
    mem[1]   = 16'h11D7;
    mem[5]   = 16'h3C96;
    mem[511] = 16'hBEEF;

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0; ready = 1'b1;

    // Reset state, sampled between edges while reset is held.
    #12;
    check("rst_busy",  busy,     0);
    check("rst_done",  done,     0);
    check("rst_valid", valid,    0);
    check("rst_data",  data,     0);
    check("rst_clke",  rom_clke, 0);
    check("rst_addr",  rom_addr, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_addr", rom_addr, 0);

    // Normal transfer: 0x2405, 0x11D7 -> 05 24 D7 11 (sum 0x111 -> 0x11).
    clear_mon();
    snap = done_cnt;
    run(9'h000, 10'd2, done_at);
    check("norm_done_at", done_at, 9 + CHK_EXTRA);
    exp_b = {16'h05, 16'h24, 16'hD7, 16'h11};
`ifdef ROM_STREAMER_CHKSUM_EN
    exp_b.push_back(16'h11);
`endif
    exp_a = {16'h000, 16'h001};
    @(negedge clk);
    check("norm_done_width", done, 0);
    check("norm_busy_after", busy, 0);
    check("norm_done_cnt", done_cnt - snap, 1);
    check_q("norm_bytes", byte_q, exp_b);
    check_q("norm_addrs", addr_q, exp_a);

    // Backpressure in HI: word 0x3C96, sink stalls five cycles on the 0x3C byte.
    clear_mon();
    ready = 1'b0;
    start = 1'b1; start_addr = 9'd5; length = 10'd1;
    @(negedge clk); start = 1'b0;           // READ
    @(negedge clk);                         // LATCH
    @(negedge clk);                         // LO
    check("bp_lo_valid", valid, 1);
    check("bp_lo_data",  data, 8'h96);
    ready = 1'b1;
    @(negedge clk);                         // HI
    ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_hi_valid%0d", j), valid, 1);
      check($sformatf("bp_hi_data%0d", j), data, 8'h3C);
      check($sformatf("bp_hi_clke%0d", j), rom_clke, 0);
      @(negedge clk);
    end
    ready = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) begin
        done_at = k;
        break;
      end
    end
    check("bp_done_at", done_at, 1 + CHK_EXTRA);
    exp_b = {16'h96, 16'h3C};
`ifdef ROM_STREAMER_CHKSUM_EN
    exp_b.push_back(16'hD2);
`endif
    exp_a = {16'h005};
    @(negedge clk);
    check_q("bp_bytes", byte_q, exp_b);
    check_q("bp_addrs", addr_q, exp_a);

    // Address wrap: 0x1FF then 0x000. Sum EF+BE+05+24 = 0x1D6 -> 0xD6.
    clear_mon();
    run(9'h1FF, 10'd2, done_at);
    check("wrap_done_at", done_at, 9 + CHK_EXTRA);
    exp_b = {16'hEF, 16'hBE, 16'h05, 16'h24};
`ifdef ROM_STREAMER_CHKSUM_EN
    exp_b.push_back(16'hD6);
`endif
    exp_a = {16'h1FF, 16'h000};
    @(negedge clk);
    check_q("wrap_bytes", byte_q, exp_b);
    check_q("wrap_addrs", addr_q, exp_a);

    // Abort in the second word's LO, coincident with a handshake.
    clear_mon();
    snap = done_cnt;
    start = 1'b1; start_addr = 9'h000; length = 10'd3;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("abort_lo_valid", valid, 1);
    check("abort_lo_data",  data, 8'hD7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  busy, 0);
    check("abort_valid", valid, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - snap, 0);
    exp_b = {16'h05, 16'h24, 16'hD7};
    check_q("abort_bytes", byte_q, exp_b);

    // Restart after abort: one word at 1 -> D7 11 (sum 0xE8).
    clear_mon();
    run(9'h001, 10'd1, done_at);
    check("restart_done_at", done_at, 5 + CHK_EXTRA);
    exp_b = {16'hD7, 16'h11};
`ifdef ROM_STREAMER_CHKSUM_EN
    exp_b.push_back(16'hE8);
`endif
    @(negedge clk);
    check_q("restart_bytes", byte_q, exp_b);

    // Zero length: no ROM access; only the checksum byte when enabled.
    clear_mon();
    run(9'h0AA, 10'd0, done_at);
    check("zero_done_at", done_at, 1 + CHK_EXTRA);
    exp_b = {};
`ifdef ROM_STREAMER_CHKSUM_EN
    exp_b.push_back(16'h00);
`endif
    exp_a = {};
    @(negedge clk);
    check("zero_busy_after", busy, 0);
    check_q("zero_bytes", byte_q, exp_b);
    check_q("zero_addrs", addr_q, exp_a);

    // Reset in the middle of HI: outputs drop before the next rising edge.
    snap = done_cnt;
    start = 1'b1; start_addr = 9'h000; length = 10'd2;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("mid_hi_valid", valid, 1);
    check("mid_hi_data",  data, 8'h24);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy",  busy, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_data",  data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", done_cnt - snap, 0);
    check("rst_mid_idle", busy, 0);
    check("rst_mid_addr", rom_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
